// File: rtl/rec_play_ctrl_pkg.sv
// Shared types for the multi-slot record/playback controller.
// Sequencer states plus a width helper for slot indices.
package rec_play_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECORD,
    PLAY,
    DONE
  } state_t;

  // Index width for n items; never below one bit
  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rec_play_ctrl_if.sv
// Button front end and sample RAM bus of the record/play controller.
// master is the front end / RAM side, slave is the controller.
interface rec_play_if #(
  parameter int ADDR_W    = 16,
  parameter int NUM_SLOTS = 4
);
  import rec_play_pkg::*;

  localparam int SLOT_W = clog2w(NUM_SLOTS);

  logic                     btn_record;
  logic                     btn_play;
  logic                     btn_stop;
  logic [SLOT_W-1:0]        slot_sel;
  logic                     loop_en;
  logic                     mem_we;
  logic                     mem_re;
  logic [SLOT_W+ADDR_W-1:0] mem_addr;
  logic                     sample_tick;
  logic                     idle;
  logic                     recording;
  logic                     playing;
  logic                     done;
  logic                     err_empty;

  modport master (
    output btn_record, btn_play, btn_stop,
    output slot_sel, loop_en,
    input  mem_we, mem_re, mem_addr,
    input  sample_tick, idle, recording,
    input  playing, done, err_empty
  );

  modport slave (
    input  btn_record, btn_play, btn_stop,
    input  slot_sel, loop_en,
    output mem_we, mem_re, mem_addr,
    output sample_tick, idle, recording,
    output playing, done, err_empty
  );

endinterface

// File: rtl/rec_play_ctrl_sample_tick_gen.sv
// Sample-rate divider: one-cycle tick every CLK_PER_SAMPLE clocks.
// Held at zero whenever en is low so each take starts phase-aligned.
module sample_tick_gen #(
  parameter int CLK_PER_SAMPLE = 2268
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(CLK_PER_SAMPLE);
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_SAMPLE - 1);

  logic [CW-1:0] cnt_q;

  assign tick = en && (cnt_q == LAST);

  // Free-run 0..LAST while enabled, clear otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (!en || cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/rec_play_ctrl.sv
// Multi-slot record/playback sequencer driving the sample RAM.
// Per-slot take lengths live in flops and are written on record exit.
module rec_play_ctrl
  import rec_play_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int NUM_SLOTS      = 4,
  parameter int CLK_PER_SAMPLE = 2268
) (
  input  logic     clk,
  input  logic     reset,
  rec_play_if.slave bus
);

  localparam int SLOT_W = clog2w(NUM_SLOTS);
  localparam int LW     = ADDR_W + 1;

  state_t            state_q;
  state_t            state_d;
  logic [SLOT_W-1:0] slot_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [LW-1:0]     len_q [NUM_SLOTS];
  logic              err_q;

  logic              active;
  logic              tick;
  logic              start;
  logic              ptr_inc;
  logic              ptr_clr;
  logic              len_we;
  logic              err_set;
  logic [LW-1:0]     len_act;
  logic [LW-1:0]     len_sel;
  logic [LW-1:0]     len_rec;
  logic              last_rd;

  assign active = (state_q == RECORD) || (state_q == PLAY);

  sample_tick_gen #(
    .CLK_PER_SAMPLE(CLK_PER_SAMPLE)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .en   (active),
    .tick (tick)
  );

  assign len_act = len_q[slot_q];
  assign len_sel = len_q[bus.slot_sel];
  assign len_rec = {1'b0, ptr_q} + LW'(tick);
  assign last_rd = ({1'b0, ptr_q} == len_act - LW'(1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath control decode
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    ptr_inc = 1'b0;
    ptr_clr = 1'b0;
    len_we  = 1'b0;
    err_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.btn_record) begin
          state_d = RECORD;
          start   = 1'b1;
        end else if (bus.btn_play) begin
          if (len_sel != '0) begin
            state_d = PLAY;
            start   = 1'b1;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      RECORD: begin
        if (bus.btn_stop || (tick && ptr_q == '1)) begin
          len_we  = 1'b1;
          state_d = DONE;
        end else if (tick) begin
          ptr_inc = 1'b1;
        end
      end
      PLAY: begin
        if (bus.btn_stop) begin
          state_d = DONE;
        end else if (tick) begin
          if (!last_rd) begin
            ptr_inc = 1'b1;
          end else if (bus.loop_en) begin
            ptr_clr = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Slot latch, sample pointer, take lengths, empty-slot flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q <= '0;
      ptr_q  <= '0;
      err_q  <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        len_q[i] <= '0;
      end
    end else begin
      err_q <= err_set;
      if (start) begin
        slot_q <= bus.slot_sel;
        ptr_q  <= '0;
      end else if (ptr_clr) begin
        ptr_q <= '0;
      end else if (ptr_inc) begin
        ptr_q <= ptr_q + ADDR_W'(1);
      end
      if (len_we) begin
        len_q[slot_q] <= len_rec;
      end
    end
  end

  assign bus.idle        = (state_q == IDLE);
  assign bus.recording   = (state_q == RECORD);
  assign bus.playing     = (state_q == PLAY);
  assign bus.done        = (state_q == DONE);
  assign bus.err_empty   = err_q;
  assign bus.sample_tick = tick;
  assign bus.mem_we      = (state_q == RECORD) && tick;
  assign bus.mem_re      = (state_q == PLAY) && tick;
  assign bus.mem_addr    = active ? {slot_q, ptr_q} : '0;

endmodule

// File: tb/tb_rec_play_ctrl.sv
// Directed bench for rec_play_ctrl with a RAM-access scoreboard.
// Small config: ADDR_W=3, NUM_SLOTS=2, CLK_PER_SAMPLE=4.
module tb_rec_play_ctrl;

  localparam int ADDR_W = 3;
  localparam int NSLOT  = 2;
  localparam int CPS    = 4;

  logic clk = 1'b0;
  logic reset;

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  // {we, re, addr[3:0]}
  logic [5:0] exp_q [$];

  rec_play_if #(.ADDR_W(ADDR_W), .NUM_SLOTS(NSLOT)) bus ();

  rec_play_ctrl #(
    .ADDR_W(ADDR_W),
    .NUM_SLOTS(NSLOT),
    .CLK_PER_SAMPLE(CPS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Pop the scoreboard on every RAM strobe; count done/err pulses
  always @(negedge clk) begin
    logic [5:0] obs;
    logic [5:0] expv;
    if (!reset) begin
      if (bus.done) done_cnt++;
      if (bus.err_empty) err_cnt++;
      if (bus.mem_we || bus.mem_re) begin
        obs  = {bus.mem_we, bus.mem_re, bus.mem_addr};
        expv = (exp_q.size() != 0) ? exp_q.pop_front() : 6'h3f;
        n_assert++;
        assert (obs === expv) else begin
          n_fail++;
          $error("FAIL mem_access observed=%0h expected=%0h", obs, expv);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_record(input logic s);
    bus.slot_sel   = s;
    bus.btn_record = 1'b1;
    step();
    bus.btn_record = 1'b0;
  endtask

  task automatic press_play(input logic s);
    bus.slot_sel = s;
    bus.btn_play = 1'b1;
    step();
    bus.btn_play = 1'b0;
  endtask

  task automatic press_stop();
    bus.btn_stop = 1'b1;
    step();
    bus.btn_stop = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    logic got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.done) begin
        got = 1'b1;
        break;
      end
      step();
    end
    chk(tag, 32'(got), 32'd1);
  endtask

  task automatic push(input logic we, input int a);
    exp_q.push_back({we, ~we, 4'(a)});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int e0;
    reset          = 1'b1;
    bus.btn_record = 1'b0;
    bus.btn_play   = 1'b0;
    bus.btn_stop   = 1'b0;
    bus.slot_sel   = 1'b0;
    bus.loop_en    = 1'b0;
    step(2);
    chk("rst_idle", 32'(bus.idle), 32'd1);
    chk("rst_rec", 32'(bus.recording), 32'd0);
    chk("rst_play", 32'(bus.playing), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err_empty), 32'd0);
    chk("rst_we", 32'(bus.mem_we), 32'd0);
    chk("rst_re", 32'(bus.mem_re), 32'd0);
    chk("rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_tick", 32'(bus.sample_tick), 32'd0);
    reset = 1'b0;
    step();

    // 1/2: record slot 1 until full, then play it back
    for (int i = 0; i < 8; i++) push(1'b1, 8 + i);
    d0 = done_cnt;
    press_record(1'b1);
    chk("t1_recording", 32'(bus.recording), 32'd1);
    step(2);
    chk("t1_no_we_c3", 32'(bus.mem_we), 32'd0);
    chk("t1_no_tick_c3", 32'(bus.sample_tick), 32'd0);
    step();
    chk("t1_we_c4", 32'(bus.mem_we), 32'd1);
    chk("t1_tick_c4", 32'(bus.sample_tick), 32'd1);
    chk("t1_addr_c4", 32'(bus.mem_addr), 32'd8);
    wait_done(40, "t2_rec_done");
    step();
    chk("t2_idle", 32'(bus.idle), 32'd1);
    chk("t2_done_pulse", 32'(bus.done), 32'd0);
    chk("t2_done_cnt", 32'(done_cnt), 32'(d0 + 1));
    chk("t2_wr_all", 32'(exp_q.size()), 32'd0);

    for (int i = 0; i < 8; i++) push(1'b0, 8 + i);
    press_play(1'b1);
    chk("t2_playing", 32'(bus.playing), 32'd1);
    wait_done(40, "t2_play_done");
    step();
    chk("t2_play_idle", 32'(bus.idle), 32'd1);
    chk("t2_rd_all", 32'(exp_q.size()), 32'd0);

    // 3: record slot 0, stop with 3rd tick
    for (int i = 0; i < 3; i++) push(1'b1, i);
    press_record(1'b0);
    step(11);
    chk("t3_we_3rd", 32'(bus.mem_we), 32'd1);
    chk("t3_addr_3rd", 32'(bus.mem_addr), 32'd2);
    press_stop();
    chk("t3_done", 32'(bus.done), 32'd1);
    step();
    chk("t3_wr_all", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 3; i++) push(1'b0, i);
    press_play(1'b0);
    wait_done(20, "t3_play_done");
    step();
    chk("t3_rd_all", 32'(exp_q.size()), 32'd0);

    // 4: looped playback of slot 0, stopped on the 7th read
    bus.loop_en = 1'b1;
    for (int i = 0; i < 7; i++) push(1'b0, i % 3);
    d0 = done_cnt;
    press_play(1'b0);
    step(27);
    chk("t4_re_7th", 32'(bus.mem_re), 32'd1);
    chk("t4_addr_7th", 32'(bus.mem_addr), 32'd0);
    chk("t4_no_done", 32'(done_cnt), 32'(d0));
    press_stop();
    chk("t4_done", 32'(bus.done), 32'd1);
    bus.loop_en = 1'b0;
    step();
    chk("t4_idle", 32'(bus.idle), 32'd1);
    chk("t4_rd_all", 32'(exp_q.size()), 32'd0);

    // 5: empty-slot play after reset, record beats play
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    e0 = err_cnt;
    press_play(1'b1);
    chk("t5_err", 32'(bus.err_empty), 32'd1);
    chk("t5_idle", 32'(bus.idle), 32'd1);
    chk("t5_not_play", 32'(bus.playing), 32'd0);
    step();
    chk("t5_err_pulse", 32'(bus.err_empty), 32'd0);
    step(4);
    chk("t5_still_idle", 32'(bus.idle), 32'd1);
    chk("t5_err_cnt", 32'(err_cnt), 32'(e0 + 1));
    bus.slot_sel   = 1'b0;
    bus.btn_record = 1'b1;
    bus.btn_play   = 1'b1;
    step();
    bus.btn_record = 1'b0;
    bus.btn_play   = 1'b0;
    chk("t5_rec_wins", 32'(bus.recording), 32'd1);
    chk("t5_rec_noplay", 32'(bus.playing), 32'd0);
    press_stop();
    chk("t5_zero_done", 32'(bus.done), 32'd1);
    step();
    press_play(1'b0);
    chk("t5_zero_len_err", 32'(bus.err_empty), 32'd1);
    step();

    // 6: reset during the 2nd write aborts the take
    push(1'b1, 8);
    press_record(1'b1);
    step(7);
    chk("t6_we_2nd", 32'(bus.mem_we), 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_we_off", 32'(bus.mem_we), 32'd0);
    chk("t6_rec_off", 32'(bus.recording), 32'd0);
    chk("t6_addr_off", 32'(bus.mem_addr), 32'd0);
    chk("t6_tick_off", 32'(bus.sample_tick), 32'd0);
    chk("t6_idle_on", 32'(bus.idle), 32'd1);
    step();
    reset = 1'b0;
    step();
    press_play(1'b1);
    chk("t6_err", 32'(bus.err_empty), 32'd1);
    step(2);
    chk("t6_q_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
